// File: rtl/button_event_arbiter.sv
// Debounces N_BTN raw inputs on a shared sample tick and serves each debounced press
// as a one-shot event to a single consumer, granted round-robin over valid/ready.
module button_event_arbiter #(
  parameter int N_BTN        = 5,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 20,
  localparam int ID_W        = $clog2(N_BTN)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] db_level,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic             evt_drop,
  output logic             tick
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int ST_W  = $clog2(STABLE_TICKS);

  logic [N_BTN-1:0] sync_p0, sync_p1;
  logic [DIV_W-1:0] div_cnt;
  logic [ST_W-1:0]  stab_cnt  [N_BTN];
  logic [ST_W-1:0]  stab_next [N_BTN];
  logic [N_BTN-1:0] db_next, rise, pending, pending_next, clr;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W:0]    pick;
  logic             slot_free, grant_vld, drop_any;

  // Returns {found, index} of the first set request after 'last', wrapping around.
  function automatic logic [ID_W:0] rr_pick(input logic [N_BTN-1:0] req,
                                           input logic [ID_W-1:0]  last);
    logic [ID_W:0] r;
    int idx;
    r = '0;
    for (int k = N_BTN; k >= 1; k--) begin
      idx = (int'(last) + k) % N_BTN;
      if (req[idx]) r = {1'b1, ID_W'(idx)};
    end
    return r;
  endfunction

  // Debounce, press detect and grant selection
  always_comb begin
    db_next = db_level;
    for (int i = 0; i < N_BTN; i++) begin
      stab_next[i] = stab_cnt[i];
      if (tick) begin
        if (sync_p1[i] == db_level[i]) begin
          stab_next[i] = '0;
        end else if (stab_cnt[i] == ST_W'(STABLE_TICKS - 1)) begin
          db_next[i]   = ~db_level[i];
          stab_next[i] = '0;
        end else begin
          stab_next[i] = stab_cnt[i] + ST_W'(1);
        end
      end
    end
    rise      = db_next & ~db_level;
    slot_free = ~evt_valid | evt_ready;
    pick      = rr_pick(pending, last_grant);
    grant_vld = slot_free & pick[ID_W];
    clr       = grant_vld ? (N_BTN'(1) << pick[ID_W-1:0]) : '0;
    // A rise on a channel being granted this cycle re-pends it rather than dropping.
    drop_any     = |(rise & pending & ~clr);
    pending_next = (pending & ~clr) | rise;
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      div_cnt    <= '0;
      tick       <= 1'b0;
      db_level   <= '0;
      for (int i = 0; i < N_BTN; i++) stab_cnt[i] <= '0;
      pending    <= '0;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_drop   <= 1'b0;
      last_grant <= ID_W'(N_BTN - 1);
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      tick     <= (div_cnt == DIV_W'(TICK_DIV - 1));
      div_cnt  <= (div_cnt == DIV_W'(TICK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      db_level <= db_next;
      for (int i = 0; i < N_BTN; i++) stab_cnt[i] <= stab_next[i];
      pending  <= pending_next;
      evt_drop <= drop_any;
      if (slot_free) begin
        evt_valid <= pick[ID_W];
        if (pick[ID_W]) begin
          evt_id     <= pick[ID_W-1:0];
          last_grant <= pick[ID_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed vector table, hand sequences for
// multi-cycle corners, and randomized traffic against a behavioural model.
module tb_button_event_arbiter;
  localparam int NB = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] db_level;
  logic          evt_valid;
  logic [1:0]    evt_id;
  logic          evt_ready;
  logic          evt_drop;
  logic          tick;

  button_event_arbiter #(.N_BTN(NB), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clock(clock), .reset_n(reset_n), .btn_raw(btn_raw), .db_level(db_level),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .evt_drop(evt_drop), .tick(tick)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural reference: counts elapsed clocks and consecutive disagreeing ticks
  // with plain integers, and serves a pending set with a modular scan.
  logic [NB-1:0] m_s1, m_s2, m_db, m_pend;
  int            m_cyc;
  int            m_run [NB];
  logic          m_tick, m_valid, m_drop;
  logic [1:0]    m_id, m_lg;

  always @(posedge clock or negedge reset_n) begin : model
    logic [NB-1:0] db_n, rise, clr;
    int run_n [NB];
    int g;
    bit free;
    if (!reset_n) begin
      m_s1 <= '0; m_s2 <= '0; m_db <= '0; m_pend <= '0; m_cyc <= 0;
      for (int i = 0; i < NB; i++) m_run[i] <= 0;
      m_tick <= 0; m_valid <= 0; m_drop <= 0; m_id <= 0; m_lg <= 2'(NB - 1);
    end else begin
      db_n = m_db;
      for (int i = 0; i < NB; i++) begin
        run_n[i] = m_run[i];
        if (m_tick) begin
          run_n[i] = (m_s2[i] != m_db[i]) ? m_run[i] + 1 : 0;
          if (run_n[i] == ST) begin
            db_n[i]  = ~m_db[i];
            run_n[i] = 0;
          end
        end
      end
      rise = db_n & ~m_db;
      free = !m_valid || evt_ready;
      g = -1;
      if (free)
        for (int k = 1; k <= NB; k++)
          if (g < 0 && m_pend[(int'(m_lg) + k) % NB]) g = (int'(m_lg) + k) % NB;
      clr = '0;
      if (g >= 0) clr[g] = 1'b1;
      m_drop <= |(rise & m_pend & ~clr);
      m_pend <= (m_pend & ~clr) | rise;
      if (free) begin
        m_valid <= (g >= 0);
        if (g >= 0) begin
          m_id <= g[1:0];
          m_lg <= g[1:0];
        end
      end
      m_tick <= ((m_cyc + 1) % TD == 0);
      m_cyc  <= m_cyc + 1;
      m_s1   <= btn_raw;
      m_s2   <= m_s1;
      m_db   <= db_n;
      for (int i = 0; i < NB; i++) m_run[i] <= run_n[i];
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_db", 32'(db_level), 32'(m_db));
      check("model_valid", 32'(evt_valid), 32'(m_valid));
      if (m_valid) check("model_id", 32'(evt_id), 32'(m_id));
      check("model_drop", 32'(evt_drop), 32'(m_drop));
      check("model_tick", 32'(tick), 32'(m_tick));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input logic [NB-1:0] raw);
    reset_n = 0; btn_raw = raw; evt_ready = 0;
    repeat (2) step();
    reset_n = 1;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 0;
    for (int c = 0; c < maxc && !ok; c++) begin
      step();
      ok = evt_valid;
    end
  endtask

  typedef struct {
    logic [NB-1:0] raw;
    logic          ready;
    int            cycles;
    logic [NB-1:0] db;
    logic          valid;
    logic [1:0]    id;
  } vec_t;

  vec_t vecs [10];

  initial begin
    bit ok;
    int drops, bad_id, accepts, stale;

    vecs[0] = '{4'b0000, 1'b1,  8, 4'b0000, 1'b0, 2'd0};
    vecs[1] = '{4'b0010, 1'b1,  6, 4'b0000, 1'b0, 2'd0};  // glitch shorter than 3 ticks
    vecs[2] = '{4'b0000, 1'b1, 30, 4'b0000, 1'b0, 2'd0};
    vecs[3] = '{4'b0100, 1'b0, 30, 4'b0100, 1'b1, 2'd2};
    vecs[4] = '{4'b0100, 1'b1,  1, 4'b0100, 1'b0, 2'd0};
    vecs[5] = '{4'b0000, 1'b1, 30, 4'b0000, 1'b0, 2'd0};
    vecs[6] = '{4'b1001, 1'b0, 30, 4'b1001, 1'b1, 2'd3};  // last grant was 2
    vecs[7] = '{4'b1001, 1'b1,  1, 4'b1001, 1'b1, 2'd0};
    vecs[8] = '{4'b1001, 1'b1,  1, 4'b1001, 1'b0, 2'd0};
    vecs[9] = '{4'b0000, 1'b1, 30, 4'b0000, 1'b0, 2'd0};

    // Reset values and first tick position
    reset_n = 0; btn_raw = 4'hF; evt_ready = 0;
    #2;
    step();
    chk_en = 1;
    check("rst_db", 32'(db_level), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_drop", 32'(evt_drop), 0);
    reset_n = 1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("first_tick_e%0d", e), 32'(tick), (e == 4) ? 1 : 0);
    end

    // Vector table
    apply_reset('0);
    foreach (vecs[v]) begin
      btn_raw = vecs[v].raw; evt_ready = vecs[v].ready;
      repeat (vecs[v].cycles) step();
      check($sformatf("vec%0d_db", v), 32'(db_level), 32'(vecs[v].db));
      check($sformatf("vec%0d_valid", v), 32'(evt_valid), 32'(vecs[v].valid));
      if (vecs[v].valid) check($sformatf("vec%0d_id", v), 32'(evt_id), 32'(vecs[v].id));
    end

    // Round-robin from reset: 0 then 3
    apply_reset('0);
    evt_ready = 1; btn_raw = 4'b1001;
    wait_valid(40, ok);
    check("rr1_seen", 32'(ok), 1);
    check("rr1_first", 32'(evt_id), 0);
    step();
    check("rr1_second_valid", 32'(evt_valid), 1);
    check("rr1_second", 32'(evt_id), 3);
    step();
    check("rr1_idle", 32'(evt_valid), 0);
    btn_raw = 0; repeat (30) step();
    btn_raw = 4'b0001;
    wait_valid(40, ok);
    check("rr_ch0_id", 32'(evt_id), 0);
    btn_raw = 0; repeat (30) step();
    // Last grant is now 0: order 3 then 0
    btn_raw = 4'b1001;
    wait_valid(40, ok);
    check("rr2_seen", 32'(ok), 1);
    check("rr2_first", 32'(evt_id), 3);
    step();
    check("rr2_second_valid", 32'(evt_valid), 1);
    check("rr2_second", 32'(evt_id), 0);
    btn_raw = 0; repeat (30) step();

    // Backpressure and drop on channel 1
    apply_reset('0);
    drops = 0; bad_id = 0;
    for (int p = 0; p < 5; p++) begin
      btn_raw = (p % 2 == 0) ? 4'b0010 : 4'b0000;
      for (int c = 0; c < 30; c++) begin
        step();
        if (evt_drop) drops++;
        if (evt_valid && evt_id != 2'd1) bad_id++;
      end
    end
    check("bp_slot_valid", 32'(evt_valid), 1);
    check("bp_id_stable", 32'(bad_id), 0);
    check("bp_drop_count", 32'(drops), 1);
    evt_ready = 1; accepts = 0; bad_id = 0;
    for (int c = 0; c < 6; c++) begin
      if (evt_valid) begin
        accepts++;
        if (evt_id != 2'd1) bad_id++;
      end
      step();
    end
    check("bp_accepts", 32'(accepts), 2);
    check("bp_accept_id", 32'(bad_id), 0);
    btn_raw = 0; repeat (30) step();

    // Reset mid-operation with an event in the slot and one pending
    apply_reset('0);
    btn_raw = 4'b1100;
    repeat (30) step();
    check("mid_valid_before", 32'(evt_valid), 1);
    check("mid_id_before", 32'(evt_id), 2);
    btn_raw = 0; reset_n = 0;
    #2;
    check("mid_rst_valid", 32'(evt_valid), 0);
    check("mid_rst_id", 32'(evt_id), 0);
    check("mid_rst_db", 32'(db_level), 0);
    check("mid_rst_drop", 32'(evt_drop), 0);
    check("mid_rst_tick", 32'(tick), 0);
    step();
    reset_n = 1; evt_ready = 1; stale = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (evt_valid) stale++;
    end
    check("mid_no_stale", 32'(stale), 0);

    // Randomized traffic, checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) btn_raw[$urandom_range(0, NB - 1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) evt_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
